// File: rtl/uart_rx_ex.sv
// uart_rx_ex: oversampling UART receiver. 3-sample majority per bit, optional
// parity, 1 or 2 checked stop bits, and a one-word holding register with a
// ready/valid handshake plus an overrun pulse when a completed frame is dropped.
module uart_rx_ex #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CntLast  = 16'(BPS_CNT - 1);
  localparam logic [15:0] CntSmp0  = 16'(BPS_CNT / 2 - 1);
  localparam logic [15:0] CntSmp1  = 16'(BPS_CNT / 2);
  localparam logic [15:0] CntDec   = 16'(BPS_CNT / 2 + 1);
  localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e               r_state, w_state_next;
  logic                 r_sync1, r_sync2, r_sync3;
  logic [1:0]           r_fill;
  logic [15:0]          r_clk_cnt;
  logic [3:0]           r_bit_idx;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_pend, r_ferr_pend, r_done;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_parity_err, r_frame_err, r_overrun;

  logic w_line, w_start_edge, w_decide, w_wrap, w_bit, w_par_exp, w_frame_done;

  assign w_line = r_sync2;
  // r_fill blocks edge detection until the chain holds real line samples, so a
  // line already low at reset release is not mistaken for a start edge.
  assign w_start_edge = (r_fill == 2'd3) && r_sync3 && !r_sync2;

  // Synchronizer, edge-detect stage and post-reset fill counter
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_fill  <= 2'd0;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start_edge) w_state_next = StStart;
      StStart: begin
        if (w_decide && w_bit) w_state_next = StIdle;
        else if (w_wrap)       w_state_next = StData;
      end
      StData:  if (w_wrap && (r_bit_idx == DataLast)) begin
        w_state_next = (PARITY != 0) ? StPar : StStop;
      end
      StPar:   if (w_wrap) w_state_next = StStop;
      StStop:  if (w_decide && (r_bit_idx == StopLast)) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: bit strobes, majority vote, expected parity, frame-complete
  always_comb begin
    w_decide     = (r_clk_cnt == CntDec);
    w_wrap       = (r_clk_cnt == CntLast);
    w_bit        = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_line) | (r_samp[1] & w_line);
    w_par_exp    = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    w_frame_done = (r_state == StStop) && w_decide && (r_bit_idx == StopLast);
  end

  // Bit-time counter, bit index and the two early majority samples
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_clk_cnt <= 16'd0;
      r_bit_idx <= 4'd0;
      r_samp    <= 2'b00;
    end else if (r_state == StIdle) begin
      r_clk_cnt <= 16'd0;
      r_bit_idx <= 4'd0;
    end else begin
      r_clk_cnt <= w_wrap ? 16'd0 : r_clk_cnt + 16'd1;
      if (w_wrap) r_bit_idx <= (w_state_next != r_state) ? 4'd0 : r_bit_idx + 4'd1;
      if (r_clk_cnt == CntSmp0) r_samp[0] <= w_line;
      if (r_clk_cnt == CntSmp1) r_samp[1] <= w_line;
    end
  end

  // Data shift register, pending error flags and completion register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_shift     <= '0;
      r_perr_pend <= 1'b0;
      r_ferr_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_frame_done;
      if ((r_state == StIdle) && w_start_edge) begin
        r_perr_pend <= 1'b0;
        r_ferr_pend <= 1'b0;
      end
      if ((r_state == StData) && w_decide) begin
        for (int unsigned i = 0; i < DATA_BITS; i++) begin
          if (r_bit_idx == 4'(i)) r_shift[i] <= w_bit;
        end
      end
      if ((r_state == StPar) && w_decide && (w_bit != w_par_exp)) r_perr_pend <= 1'b1;
      if ((r_state == StStop) && w_decide && !w_bit) r_ferr_pend <= 1'b1;
    end
  end

  // Output holding register: load when free or being drained, else drop
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_perr_pend;
          r_frame_err  <= r_ferr_pend;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_ex.sv
// Bench for uart_rx_ex: three instances (8N1, 8E1, 7O2) at 10 clocks per bit,
// directed corner cases plus random frames checked against a frame-level model.
module tb_uart_rx_ex;

  localparam int BPS = 10;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd;
  logic [2:0] rdy;
  wire  [2:0] vld, perr, ferr, ovr;
  wire  [7:0] d0, d1;
  wire  [6:0] d2;
  wire  [7:0] dd [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t cap_q[$];
  int   rd_ptr   = 0;
  int   ovr_cnt [3] = '{0, 0, 0};

  assign dd[0] = d0;
  assign dd[1] = d1;
  assign dd[2] = {1'b0, d2};

  always #5 clk = ~clk;

  uart_rx_ex #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1)) u_dut_8n1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[0]), .rx_data(d0), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0])
  );

  uart_rx_ex #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1)) u_dut_8e1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[1]), .rx_data(d1), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1])
  );

  uart_rx_ex #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(1),
               .STOP_BITS(2)) u_dut_7o2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd[2]), .rx_data(d2), .rx_valid(vld[2]),
    .rx_ready(rdy[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2])
  );

  // Record every accepted word and count overrun-high cycles per instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (vld[k] && rdy[k]) begin
        cap_q.push_back('{k: k, d: dd[k], pe: perr[k], fe: ferr[k]});
      end
      if (ovr[k]) ovr_cnt[k] = ovr_cnt[k] + 1;
    end
  end

  function automatic int nbits_of(input int k);
    return (k == 2) ? 7 : 8;
  endfunction

  function automatic int pmode_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int nstop_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  // Frame-level reference: {parity_err, frame_err, data}
  function automatic logic [9:0] model(input int k, input logic [7:0] data, input logic pbit,
                                       input logic [1:0] stops);
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         ones;
    d    = (nbits_of(k) == 7) ? (data & 8'h7f) : data;
    ones = $countones(d) + int'(pbit);
    pe   = 1'b0;
    if (pmode_of(k) == 1) pe = (ones % 2) != 1;
    if (pmode_of(k) == 2) pe = (ones % 2) != 0;
    fe = 1'b0;
    for (int s = 0; s < nstop_of(k); s++) if (!stops[s]) fe = 1'b1;
    return {pe, fe, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input int n);
    rxd[k] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // gbit >= 0 inverts that data bit for one clock on its middle sample
  task automatic send_frame(input int k, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input int gbit);
    logic b;
    drive(k, 1'b0, BPS);
    for (int i = 0; i < nbits_of(k); i++) begin
      b = data[i];
      if (i == gbit) begin
        drive(k, b, 6);
        drive(k, ~b, 1);
        drive(k, b, BPS - 7);
      end else begin
        drive(k, b, BPS);
      end
    end
    if (pmode_of(k) != 0) drive(k, pbit, BPS);
    for (int s = 0; s < nstop_of(k); s++) drive(k, stops[s], BPS);
  endtask

  task automatic check_rx(input int k, input logic [9:0] m, input string tag);
    int n;
    n = cap_q.size() - rd_ptr;
    check({tag, "_count"}, 32'(n), 32'd1);
    if (n > 0) begin
      check({tag, "_inst"}, 32'(cap_q[rd_ptr].k), 32'(k));
      check({tag, "_data"}, 32'(cap_q[rd_ptr].d), 32'(m[7:0]));
      check({tag, "_perr"}, 32'(cap_q[rd_ptr].pe), 32'(m[9]));
      check({tag, "_ferr"}, 32'(cap_q[rd_ptr].fe), 32'(m[8]));
    end
    rd_ptr = cap_q.size();
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 32'(cap_q.size() - rd_ptr), 32'd0);
    rd_ptr = cap_q.size();
  endtask

  task automatic txrx(input int k, input logic [7:0] data, input logic pbit,
                      input logic [1:0] stops, input int gbit, input string tag);
    send_frame(k, data, pbit, stops, gbit);
    drive(k, 1'b1, 3 * BPS);
    check_rx(k, model(k, data, pbit, stops), tag);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_valid"}, 32'(vld[k]), 32'd0);
      check({tag, "_data"}, 32'(dd[k]), 32'd0);
      check({tag, "_perr"}, 32'(perr[k]), 32'd0);
      check({tag, "_ferr"}, 32'(ferr[k]), 32'd0);
      check({tag, "_ovr"}, 32'(ovr[k]), 32'd0);
    end
  endtask

  initial begin
    int         snap;
    logic [9:0] m;

    rst_n = 1'b0;
    rxd   = 3'b111;
    rdy   = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2 * BPS) @(posedge clk);
    #1;

    // Basic frames and parity handling
    txrx(0, 8'hA5, 1'b0, 2'b11, -1, "8n1_a5");
    txrx(1, 8'h37, 1'b0, 2'b11, -1, "8e1_37_badpar");
    txrx(2, 8'h55, 1'b1, 2'b11, -1, "7o2_55_goodpar");
    txrx(2, 8'h55, 1'b0, 2'b11, -1, "7o2_55_badpar");
    txrx(2, 8'h13, 1'b0, 2'b10, -1, "7o2_stop2_low");

    // Break: stop bit low and line held low; only one frame until a new fall
    send_frame(0, 8'h00, 1'b0, 2'b00, -1);
    drive(0, 1'b0, 12 * BPS);
    check_rx(0, model(0, 8'h00, 1'b0, 2'b00), "break");
    drive(0, 1'b1, 2 * BPS);
    txrx(0, 8'h3C, 1'b0, 2'b11, -1, "after_break");

    // Overrun: second frame dropped while the first is held
    rdy[0] = 1'b0;
    snap   = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 2'b11, -1);
    drive(0, 1'b1, 3 * BPS);
    check("hold_valid", 32'(vld[0]), 32'd1);
    check("hold_data", 32'(dd[0]), 32'h11);
    send_frame(0, 8'h22, 1'b0, 2'b11, -1);
    drive(0, 1'b1, 3 * BPS);
    check("ovr_data_kept", 32'(dd[0]), 32'h11);
    check("ovr_valid_kept", 32'(vld[0]), 32'd1);
    check("ovr_pulse_cycles", 32'(ovr_cnt[0] - snap), 32'd1);
    check_quiet("ovr_no_accept");
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("drain_valid_low", 32'(vld[0]), 32'd0);
    check_rx(0, model(0, 8'h11, 1'b0, 2'b11), "drain");

    // Glitches: short idle pulse rejected, one-clock data glitch outvoted
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 3 * BPS);
    check_quiet("idle_glitch");
    txrx(0, 8'h96, 1'b0, 2'b11, 3, "data_glitch_b3");
    txrx(1, 8'h4E, 1'b1, 2'b11, 0, "data_glitch_b0");

    // Random frames against the model
    for (int it = 0; it < 24; it++) begin
      int         k;
      int         gbit;
      logic [7:0] data;
      logic       pbit;
      logic [1:0] stops;
      k     = int'($urandom_range(0, 2));
      data  = 8'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      gbit  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, unsigned'(nbits_of(k) - 1)))
                                          : -1;
      txrx(k, data, pbit, stops, gbit, "rand");
    end

    // Reset mid-frame: held word on the 8E1 instance must clear, frame abandoned
    rdy[1] = 1'b0;
    send_frame(1, 8'h5A, 1'b1, 2'b11, -1);
    drive(1, 1'b1, 3 * BPS);
    m = model(1, 8'h5A, 1'b1, 2'b11);
    check("pre_rst_valid", 32'(vld[1]), 32'd1);
    check("pre_rst_perr", 32'(perr[1]), 32'(m[9]));
    rxd[2] = 1'b0;
    drive(0, 1'b0, BPS);
    for (int i = 0; i < 4; i++) drive(0, m[i] ^ 1'b1, BPS);
    drive(0, 1'b0, 5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rxd[0] = 1'b1;
    rdy[1] = 1'b1;
    repeat (3 * BPS) @(posedge clk);
    #1;
    check_quiet("rst_abandon");
    rxd[2] = 1'b1;
    repeat (2 * BPS) @(posedge clk);
    #1;
    check_quiet("rst_low_line");
    txrx(0, 8'hC3, 1'b0, 2'b11, -1, "post_rst_c3");
    txrx(2, 8'h2B, 1'b0, 2'b11, -1, "post_rst_7o2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ex.md
UART_RX_EX -- requirements
Module: uart_rx_ex

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, meaning baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit, range 8..65535.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked, legal 1 or 2.
REQ-006 SHALL have port sys_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high, LSB first.
REQ-009 SHALL have port rx_data, output, DATA_BITS, received word.
REQ-010 SHALL have port rx_valid, output, 1, rx_data/flags hold a word.
REQ-011 SHALL have port rx_ready, input, 1, consumer accepts when rx_valid & rx_ready.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch on the held word; 0 when PARITY=0.
REQ-013 SHALL have port frame_err, output, 1, a stop bit sampled 0 on the held word.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass uart_rxd through a 2-flop synchronizer; stage 3 flop gives edge detection; start = sync high previous cycle, low now.
REQ-016 SHALL sample each bit by 3-sample majority at clk_cnt = BPS_CNT/2-1, BPS_CNT/2, BPS_CNT/2+1; decision taken at BPS_CNT/2+1.
REQ-017 SHALL use states IDLE, START, DATA, PAR, STOP; clk_cnt counts 0..BPS_CNT-1, wraps to 0 and advances bit index at BPS_CNT-1.
REQ-018 IDLE -> START on start edge, clk_cnt cleared; edges ignored in all other states.
REQ-019 START: majority 1 at decision -> IDLE (glitch rejected, no output); else continue to DATA at wrap.
REQ-020 DATA: bit i stored to rx shift position i; after bit DATA_BITS-1 wrap -> PAR if PARITY!=0, else STOP.
REQ-021 PAR: computed parity = XOR of data bits, expected bit = ~XOR for odd, XOR for even; mismatch sets pending parity error.
REQ-022 STOP: each stop bit majority 0 sets pending frame error; at decision of last stop bit -> IDLE immediately (no wait for wrap), frame complete.
REQ-023 On frame complete, next cycle: if rx_valid=0 or (rx_valid & rx_ready) that cycle, load rx_data, parity_err, frame_err and set rx_valid=1.
REQ-024 If rx_valid=1 and rx_ready=0 at completion: keep held word and flags unchanged, pulse overrun for exactly 1 cycle, discard new frame.
REQ-025 rx_valid SHALL clear the cycle after rx_valid & rx_ready unless REQ-023 reloads in that same cycle; rx_data/flags stable while rx_valid=1.
REQ-026 Frame with errors SHALL still be delivered (rx_valid=1) with its flags; break (all-zero line) yields frame_err=1, rx_data=0.
REQ-027 Latency: rx_valid rises 2 cycles after the last stop-bit decision edge (1 cycle completion register + 1 cycle output load).
REQ-028 Widths: clk_cnt 16 bits, bit index 4 bits; no truncation of BPS_CNT/2+1.

Reset
REQ-029 While sys_rst_n=0 at a rising edge: state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no output; after release a line already low SHALL NOT start a frame until a new high-to-low edge.

Verification (CLK_FREQ=1000000, UART_BPS=100000, BPS_CNT=10)
REQ-031 8N1 byte 0xA5, rx_ready=1 -> rx_valid 1-cycle pulse, rx_data=0xA5, both errors 0.
REQ-032 8E1 0x37 with parity bit 0 (correct 1) -> rx_data=0x37, parity_err=1; 7O2 0x55 correct parity -> parity_err=0.
REQ-033 Stop bit driven 0, then 12 bit-times low -> frame_err=1, rx_data=0x00, no second frame until line returns high then falls.
REQ-034 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulse 1 cycle; raise rx_ready -> 0x11 accepted, rx_valid=0.
REQ-035 Low glitch of 3 clocks on idle line -> no rx_valid; single-clock glitch inside a data bit -> word correct via majority.
REQ-036 Assert sys_rst_n=0 during DATA bit 4 for 2 cycles -> all outputs 0 next edge; next clean frame 0xC3 received correctly.
